vinput_sweep_ctrl: RTL and testbench
====================================

Name: vinput_sweep_ctrl

Overview:
- Sequencer for the backbone2vinput datapath.
- On a start command it latches one frame of configuration: x_initial, the alpha_u table and J backbone words.
- It presents the configuration to the datapath, then sweeps ind_j from 0 to J-1. For each index it issues one backbone word, waits for vinput_tvalid and stores the returned vinput in a J-entry result buffer.
- It reports completion and per-index timeout errors to the frame-level controller above it.

Parameters:
- J, 14, number of backbone indices swept per frame
- I, 7, passed through for consistency with the datapath; not used internally
- A, 2, alphabet size per index
- TIMEOUT, 1024, maximum cycles spent waiting for one vinput_tvalid (1..65535)
- Derived, local: J_WIDTH = $clog2(J)+1; A_WIDTH = $clog2(A)+1

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle frame request; sampled only in IDLE
- x_initial_in  in  J*A_WIDTH  frame initial symbols
- alpha_u_in  in  J*A*64  frame alpha table (IEEE-754 doubles)
- backbone_in  in  J*64  backbone word per index; slice j = bits [64*j+63:64*j]
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the sweep completes
- err_timeout  out  J  bit j set if index j timed out; valid with done, held until the next start
- vinput_vec  out  J*64  collected results; slice j = result for index j; held until the next start
- x_initial  out  J*A_WIDTH  to datapath
- x_initial_tvalid  out  1  to datapath
- alpha_u  out  J*A*64  to datapath
- alpha_u_tvalid  out  1  to datapath
- ind_j  out  J_WIDTH  to datapath
- ind_j_tvalid  out  1  to datapath
- backbone  out  64  to datapath
- backbone_tvalid  out  1  to datapath
- vinput  in  64  from datapath
- vinput_tvalid  in  1  from datapath

Behaviour:
- Reset values (async assert, sync deassert): all outputs are 0; state IDLE; j counter 0; timeout counter 0; internal latches 0.
- States: IDLE, LOAD, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 at an edge latches x_initial_in, alpha_u_in and backbone_in.
  - The same edge clears vinput_vec and err_timeout, sets j=0 and moves to LOAD.
- LOAD (1 cycle):
  - x_initial/alpha_u driven from the latches; x_initial_tvalid = alpha_u_tvalid = 1.
  - Next state ISSUE.
- ISSUE (1 cycle):
  - ind_j = j; backbone = latched slice j; ind_j_tvalid = backbone_tvalid = 1.
  - Timeout counter cleared; next state WAIT.
- WAIT:
  - All tvalid outputs are 0.
  - ind_j, backbone, x_initial and alpha_u keep their last values; the data outputs are never zeroed mid-frame.
  - On an edge with vinput_tvalid=1: store vinput in slice j.
  - Otherwise, when the counter reaches TIMEOUT-1: set err_timeout[j], leave slice j at 0.
  - After either event: if j==J-1 go to DONE, else j=j+1 and go to ISSUE.
  - If vinput_tvalid and the timeout occur at the same edge, vinput_tvalid wins and no error is recorded.
- DONE (1 cycle): done=1; next state IDLE; busy drops in the same cycle as done deasserts.
- busy is 1 in LOAD, ISSUE, WAIT and DONE.
- start while not IDLE is ignored; no queuing.
- vinput_tvalid outside WAIT is ignored and no result is written. A late response after a timeout therefore does not corrupt index j+1 unless it arrives during j+1's WAIT, which is accepted by design.
- Latency:
  - Datapath response L cycles after the ISSUE cycle, L≥1: per index 1+L cycles.
  - Frame: the start edge is followed by 1 (LOAD) + J*(1+L) cycles before the done pulse.
- rst_n asserted mid-frame: immediate return to IDLE with all outputs 0. Partial results are discarded.
- j counter width is J_WIDTH; j never exceeds J-1.

Test Plan:
- Basic sweep. Setup: J=14, stub datapath returning vinput = backbone_in[j] + j (integer add on the bit pattern) 3 cycles after backbone_tvalid; backbone_in[j] = 64'h3FF0000000000000.
  - Required: ind_j sequence 0..13.
  - Required: done exactly 1+14*4 = 57 cycles after the start edge.
  - Required: vinput_vec slice 7 = 64'h3FF0000000000007; err_timeout = 0.
- Config handshake: x_initial_in alternating 2'b01/2'b00, alpha_u_in with [0][1] = 64'h403C000000000000.
  - Required: x_initial_tvalid and alpha_u_tvalid high for exactly one cycle, the cycle after start.
  - Required: outputs equal the inputs latched at start, even if the inputs change afterwards.
- Timeout. Setup: TIMEOUT=16; stub silent for j=5 only.
  - Required: err_timeout = 14'h0020; slice 5 = 0; the other slices correct.
  - Required: done delayed by 16-4 = 12 cycles versus the basic sweep.
- Tie: vinput_tvalid arrives exactly on the TIMEOUT-1 count edge for j=2.
  - Required: slice 2 stored; err_timeout[2] = 0.
- Busy rules: start pulsed during WAIT of j=3; vinput_tvalid pulsed while IDLE.
  - Required: no restart; vinput_vec unchanged; exactly one done pulse.
- Reset mid-frame: rst_n low during j=9, then a new start.
  - Required: all outputs 0 immediately; the new sweep starts at ind_j=0 and completes normally.

Source files
------------

// File: rtl/vinput_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// vinput_sweep_ctrl_if
//
// Purpose: groups the signals between the sweep controller and the
// backbone2vinput datapath.
//
// Handshake semantics: every *_tvalid is a one-cycle qualifier with no ready
// counterpart. A word is transferred on each rising edge where its tvalid is
// high, and the receiver must accept it on that edge. The data signals may
// hold stale values while their tvalid is low and carry no meaning then.
//
// Signal summary:
//   x_initial / x_initial_tvalid   ctrl -> datapath  frame initial symbols
//   alpha_u   / alpha_u_tvalid     ctrl -> datapath  frame alpha table
//   ind_j     / ind_j_tvalid       ctrl -> datapath  backbone index under work
//   backbone  / backbone_tvalid    ctrl -> datapath  backbone word for ind_j
//   vinput    / vinput_tvalid      datapath -> ctrl  result for ind_j
//
// Modports: master = sweep controller, slave = datapath.
// ---------------------------------------------------------------------------
interface vinput_sweep_ctrl_if #(
    parameter int J = 14,
    parameter int A = 2
);
    localparam int J_WIDTH = $clog2(J) + 1;
    localparam int A_WIDTH = $clog2(A) + 1;

    logic [J*A_WIDTH-1:0] x_initial;
    logic                 x_initial_tvalid;
    logic [J*A*64-1:0]    alpha_u;
    logic                 alpha_u_tvalid;
    logic [J_WIDTH-1:0]   ind_j;
    logic                 ind_j_tvalid;
    logic [63:0]          backbone;
    logic                 backbone_tvalid;
    logic [63:0]          vinput;
    logic                 vinput_tvalid;

    modport master (
        output x_initial, x_initial_tvalid,
        output alpha_u, alpha_u_tvalid,
        output ind_j, ind_j_tvalid,
        output backbone, backbone_tvalid,
        input  vinput, vinput_tvalid
    );

    modport slave (
        input  x_initial, x_initial_tvalid,
        input  alpha_u, alpha_u_tvalid,
        input  ind_j, ind_j_tvalid,
        input  backbone, backbone_tvalid,
        output vinput, vinput_tvalid
    );
endinterface

// File: rtl/vinput_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// vinput_sweep_ctrl
//
// Purpose: frame sequencer for the backbone2vinput datapath. On start it
// latches one frame of configuration (x_initial, alpha_u table, J backbone
// words), presents the configuration once, then sweeps ind_j = 0..J-1,
// issuing one backbone word per index and collecting the returned vinput
// into a J-entry result buffer. Indices whose response does not arrive in
// time are flagged in err_timeout and leave their result slice at zero.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   start           one-cycle frame request, honoured only while idle
//   x_initial_in    frame initial symbols            (J*A_WIDTH bits)
//   alpha_u_in      frame alpha table, doubles        (J*A*64 bits)
//   backbone_in     backbone word per index, slice j  (J*64 bits)
//   busy            high while a frame is in progress
//   done            one-cycle pulse at the end of the sweep
//   err_timeout     bit j set when index j timed out; held until next start
//   vinput_vec      collected results, slice j; held until next start
//   state_dbg       current FSM state encoding
//   dp              datapath bus (master side)
// ---------------------------------------------------------------------------
module vinput_sweep_ctrl #(
    parameter int J       = 14,
    parameter int I       = 7,
    parameter int A       = 2,
    parameter int TIMEOUT = 1024,
    localparam int J_WIDTH = $clog2(J) + 1,
    localparam int A_WIDTH = $clog2(A) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [J*A_WIDTH-1:0]     x_initial_in,
    input  logic [J*A*64-1:0]        alpha_u_in,
    input  logic [J*64-1:0]          backbone_in,
    output logic                     busy,
    output logic                     done,
    output logic [J-1:0]             err_timeout,
    output logic [J*64-1:0]          vinput_vec,
    output logic [2:0]               state_dbg,
    vinput_sweep_ctrl_if.master      dp
);

    // I only exists so the parameter set matches the datapath; it is
    // checked for sanity together with TIMEOUT.
    if (TIMEOUT < 1 || TIMEOUT > 65535 || I < 1) begin : g_param_check
        $error("vinput_sweep_ctrl: TIMEOUT must be 1..65535 and I >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [J_WIDTH-1:0] J_LAST  = J_WIDTH'(J - 1);
    localparam logic [15:0]        TO_LAST = 16'(TIMEOUT - 1);

    state_t               state_q;
    state_t               state_d;
    logic [J_WIDTH-1:0]   j_q;
    logic [15:0]          cnt_q;
    logic [J*A_WIDTH-1:0] x_lat;
    logic [J*A*64-1:0]    alpha_lat;
    logic [J*64-1:0]      bb_lat;
    logic [J*64-1:0]      vec_q;
    logic [J-1:0]         err_q;

    logic frame_start;
    logic wait_hit;
    logic wait_to;
    logic wait_end;
    logic last_j;

    assign frame_start = (state_q == S_IDLE) && start;
    // A response on the same edge as the timeout wins: wait_to is masked
    // by vinput_tvalid so the result is stored and no error is recorded.
    assign wait_hit    = (state_q == S_WAIT) && dp.vinput_tvalid;
    assign wait_to     = (state_q == S_WAIT) && !dp.vinput_tvalid && (cnt_q >= TO_LAST);
    assign wait_end    = wait_hit || wait_to;
    assign last_j      = (j_q == J_LAST);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (wait_end) begin
                    state_d = last_j ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs. The data outputs come straight from the frame latches
    // and the index counter, so they hold their values through WAIT and
    // only the tvalid strobes depend on the state.
    // ------------------------------------------------------------------
    always_comb begin
        busy                = (state_q != S_IDLE);
        done                = (state_q == S_DONE);
        dp.x_initial_tvalid = (state_q == S_LOAD);
        dp.alpha_u_tvalid   = (state_q == S_LOAD);
        dp.ind_j_tvalid     = (state_q == S_ISSUE);
        dp.backbone_tvalid  = (state_q == S_ISSUE);
        dp.backbone         = '0;
        for (int k = 0; k < J; k++) begin
            if (j_q == J_WIDTH'(k)) begin
                dp.backbone = bb_lat[k*64 +: 64];
            end
        end
    end

    assign dp.x_initial = x_lat;
    assign dp.alpha_u   = alpha_lat;
    assign dp.ind_j     = j_q;
    assign vinput_vec   = vec_q;
    assign err_timeout  = err_q;
    assign state_dbg    = state_q;

    // ------------------------------------------------------------------
    // Frame latches, index counter and result buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_lat     <= '0;
            alpha_lat <= '0;
            bb_lat    <= '0;
            vec_q     <= '0;
            err_q     <= '0;
            j_q       <= '0;
        end else begin
            if (frame_start) begin
                x_lat     <= x_initial_in;
                alpha_lat <= alpha_u_in;
                bb_lat    <= backbone_in;
                vec_q     <= '0;
                err_q     <= '0;
                j_q       <= '0;
            end
            // j stays at J-1 after the last index so it never leaves 0..J-1.
            if (wait_end && !last_j) begin
                j_q <= j_q + 1'b1;
            end
            for (int k = 0; k < J; k++) begin
                if (j_q == J_WIDTH'(k)) begin
                    if (wait_hit) begin
                        vec_q[k*64 +: 64] <= dp.vinput;
                    end
                    if (wait_to) begin
                        err_q[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Timeout counter. It reads 0 during ISSUE and k during the k-th WAIT
    // cycle, so a timed-out index occupies exactly TIMEOUT cycles
    // (ISSUE plus TIMEOUT-1 WAIT cycles). It is zero whenever the FSM is
    // outside ISSUE/WAIT and after every WAIT exit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == S_ISSUE || (state_q == S_WAIT && !wait_end)) begin
            cnt_q <= cnt_q + 16'd1;
        end else begin
            cnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_vinput_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vinput_sweep_ctrl
//
// Purpose: self-checking bench for vinput_sweep_ctrl with a stub datapath
// that answers vinput = backbone + ind_j a programmable number of cycles
// after each backbone_tvalid (0 = silent).
// ---------------------------------------------------------------------------
module tb_vinput_sweep_ctrl;

    localparam int J       = 14;
    localparam int I       = 7;
    localparam int A       = 2;
    localparam int TIMEOUT = 16;
    localparam int AW      = $clog2(A) + 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    always #5 clk = ~clk;

    logic [J*AW-1:0]   x_initial_in;
    logic [J*A*64-1:0] alpha_u_in;
    logic [J*64-1:0]   backbone_in;
    logic              busy;
    logic              done;
    logic [J-1:0]      err_timeout;
    logic [J*64-1:0]   vinput_vec;
    logic [2:0]        state_dbg;

    vinput_sweep_ctrl_if #(.J(J), .A(A)) dp_if ();

    vinput_sweep_ctrl #(.J(J), .I(I), .A(A), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .x_initial_in (x_initial_in),
        .alpha_u_in   (alpha_u_in),
        .backbone_in  (backbone_in),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout),
        .vinput_vec   (vinput_vec),
        .state_dbg    (state_dbg),
        .dp           (dp_if)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard state ----------------
    logic [63:0]     exp_q[$];   // expected ind_j sequence
    logic [63:0]     res_q[$];   // expected result slices
    logic [63:0]     exp_bb [J];
    logic [J*64-1:0] last_vec;
    logic [63:0]     jexp;
    int              lat_tab [J];
    int              edge_cnt = 0;
    int              load_cnt = 0;
    int              done_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- stub datapath ----------------
    int          resp_cnt    = 0;
    logic        resp_v      = 1'b0;
    logic [63:0] resp_d      = '0;
    logic        extra_pulse = 1'b0;
    logic [63:0] extra_d     = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            resp_cnt <= 0;
            resp_v   <= 1'b0;
        end else if (dp_if.backbone_tvalid) begin
            resp_cnt <= lat_tab[int'(dp_if.ind_j)];
            resp_d   <= dp_if.backbone + 64'(dp_if.ind_j);
            resp_v   <= 1'b0;
        end else if (resp_cnt > 0) begin
            resp_cnt <= resp_cnt - 1;
            resp_v   <= (resp_cnt == 1);
        end else begin
            resp_v <= 1'b0;
        end
    end

    assign dp_if.vinput_tvalid = resp_v | extra_pulse;
    assign dp_if.vinput        = extra_pulse ? extra_d : resp_d;

    // ---------------- monitor: ind_j / backbone scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (dp_if.x_initial_tvalid) load_cnt <= load_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (dp_if.ind_j_tvalid) begin
                check_eq("bb_tvalid_with_ind_j", 64'(dp_if.backbone_tvalid), 64'd1);
                check_eq("ind_j_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    jexp = exp_q.pop_front();
                    check_eq("ind_j", 64'(dp_if.ind_j), jexp);
                    if (jexp < 64'(J)) check_eq("backbone", dp_if.backbone, exp_bb[int'(jexp)]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_inputs(input bit rand_bb);
        for (int j = 0; j < J; j++) begin
            x_initial_in[AW*j +: AW] = (j % 2 == 0) ? AW'(1) : AW'(0);
            backbone_in[64*j +: 64]  = rand_bb ? {$urandom, $urandom} : 64'h3FF0000000000000;
            lat_tab[j]               = 3;
        end
        for (int k = 0; k < J*A; k++) alpha_u_in[64*k +: 64] = {$urandom, $urandom};
        alpha_u_in[64*1 +: 64] = 64'h403C000000000000;
    endtask

    task automatic run_frame(input string name, input int abort_j, input bit poke_busy);
        logic [63:0]       exp_res [J];
        logic [J-1:0]      exp_err;
        logic [J*AW-1:0]   x_save;
        logic [J*A*64-1:0] a_save;
        int exp_cycles, start_edge, load_base, done_base;
        bit got, poked;
        exp_cycles = 1;
        exp_err    = '0;
        got        = 1'b0;
        poked      = 1'b0;
        for (int j = 0; j < J; j++) begin
            exp_bb[j] = backbone_in[64*j +: 64];
            exp_q.push_back(64'(j));
            if (lat_tab[j] == 0 || lat_tab[j] > TIMEOUT - 1) begin
                exp_err[j] = 1'b1;
                exp_res[j] = '0;
                exp_cycles += TIMEOUT;
            end else begin
                exp_res[j] = exp_bb[j] + 64'(j);
                exp_cycles += 1 + lat_tab[j];
            end
            res_q.push_back(exp_res[j]);
            last_vec[64*j +: 64] = exp_res[j];
        end
        x_save    = x_initial_in;
        a_save    = alpha_u_in;
        load_base = load_cnt;
        done_base = done_cnt;

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        start_edge = edge_cnt;
        // Inputs change right after the start edge; outputs must keep the latched frame.
        x_initial_in = ~x_initial_in;
        alpha_u_in   = ~alpha_u_in;
        backbone_in  = ~backbone_in;

        @(negedge clk);  // LOAD
        check_eq({name, "_load_busy"}, 64'(busy), 64'd1);
        check_eq({name, "_load_tvalids"},
                 64'({dp_if.x_initial_tvalid, dp_if.alpha_u_tvalid, dp_if.ind_j_tvalid}), 64'b110);
        check_eq({name, "_x_initial"}, 64'(dp_if.x_initial), 64'(x_save));
        check_eq({name, "_alpha_u_eq"}, 64'(dp_if.alpha_u == a_save), 64'd1);
        check_eq({name, "_alpha_u_0_1"}, dp_if.alpha_u[64*1 +: 64], a_save[64*1 +: 64]);

        for (int c = 0; c < 4000 && !got; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (abort_j >= 0 && dp_if.ind_j_tvalid && int'(dp_if.ind_j) == abort_j) begin
                rst_n = 1'b0;
                #1;
                check_eq({name, "_rst_busy_done"}, 64'({busy, done}), 64'd0);
                check_eq({name, "_rst_err"}, 64'(err_timeout), 64'd0);
                check_eq({name, "_rst_vec_zero"}, 64'(vinput_vec == '0), 64'd1);
                check_eq({name, "_rst_x_initial"}, 64'(dp_if.x_initial), 64'd0);
                check_eq({name, "_rst_alpha_zero"}, 64'(dp_if.alpha_u == '0), 64'd1);
                check_eq({name, "_rst_ind_j"}, 64'(dp_if.ind_j), 64'd0);
                check_eq({name, "_rst_backbone"}, dp_if.backbone, 64'd0);
                check_eq({name, "_rst_tvalids"}, 64'({dp_if.x_initial_tvalid, dp_if.alpha_u_tvalid,
                         dp_if.ind_j_tvalid, dp_if.backbone_tvalid}), 64'd0);
                check_eq({name, "_rst_state"}, 64'(state_dbg), 64'd0);
                exp_q.delete();
                res_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                repeat (6) @(negedge clk);
                return;
            end
            if (poke_busy && !poked && busy && !dp_if.ind_j_tvalid && int'(dp_if.ind_j) == 3) begin
                poked = 1'b1;
                start = 1'b1;
            end
            if (done) got = 1'b1;
        end
        start = 1'b0;

        check_eq({name, "_done_seen"}, 64'(got), 64'd1);
        if (got) begin
            check_eq({name, "_done_latency"}, 64'(edge_cnt - start_edge), 64'(exp_cycles));
            check_eq({name, "_err_timeout"}, 64'(err_timeout), 64'(exp_err));
            for (int j = 0; j < J; j++) begin
                check_eq($sformatf("%s_slice%0d", name, j), vinput_vec[64*j +: 64], res_q.pop_front());
            end
            check_eq({name, "_ind_j_all_issued"}, 64'(exp_q.size()), 64'd0);
        end
        exp_q.delete();
        res_q.delete();
        @(negedge clk);
        check_eq({name, "_after_done"}, 64'({done, busy}), 64'd0);
        repeat (3) @(negedge clk);
        check_eq({name, "_load_cycles"}, 64'(load_cnt - load_base), 64'd1);
        check_eq({name, "_done_pulses"}, 64'(done_cnt - done_base), 64'd1);
        if (poke_busy) check_eq({name, "_poke_applied"}, 64'(poked), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        set_inputs(1'b0);
        repeat (3) @(negedge clk);
        check_eq("reset_busy_done", 64'({busy, done}), 64'd0);
        check_eq("reset_err", 64'(err_timeout), 64'd0);
        check_eq("reset_vec_zero", 64'(vinput_vec == '0), 64'd1);
        check_eq("reset_tvalids", 64'({dp_if.x_initial_tvalid, dp_if.alpha_u_tvalid,
                 dp_if.ind_j_tvalid, dp_if.backbone_tvalid}), 64'd0);
        check_eq("reset_state", 64'(state_dbg), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic sweep, constant backbone, L = 3
        set_inputs(1'b0);
        run_frame("basic", -1, 1'b0);
        check_eq("basic_slice7", vinput_vec[64*7 +: 64], 64'h3FF0000000000007);

        // vinput_tvalid while idle must be ignored
        extra_d = {$urandom, $urandom};
        @(negedge clk);
        extra_pulse = 1'b1;
        @(negedge clk);
        extra_pulse = 1'b0;
        @(negedge clk);
        check_eq("idle_pulse_vec_kept", 64'(vinput_vec == last_vec), 64'd1);
        check_eq("idle_pulse_state", 64'(state_dbg), 64'd0);

        // Timeout on j = 5
        set_inputs(1'b0);
        lat_tab[5] = 0;
        run_frame("timeout", -1, 1'b0);
        check_eq("timeout_err_mask", 64'(err_timeout), 64'h0020);

        // Tie: response exactly at the TIMEOUT-1 count for j = 2
        set_inputs(1'b1);
        lat_tab[2] = TIMEOUT - 1;
        run_frame("tie", -1, 1'b0);

        // Random latencies including one over the limit
        set_inputs(1'b1);
        for (int j = 0; j < J; j++) lat_tab[j] = $urandom_range(1, 6);
        lat_tab[11] = TIMEOUT + 2;
        run_frame("random_lat", -1, 1'b0);

        // start while busy is ignored
        set_inputs(1'b1);
        run_frame("busy_start", -1, 1'b1);

        // Reset during j = 9, then a clean frame
        set_inputs(1'b1);
        run_frame("abort", 9, 1'b0);
        set_inputs(1'b1);
        run_frame("after_reset", -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog expired");
    end

endmodule
